// File: rtl/mult_seq_pkg.sv
// Shared types for the sequential shift-add multiplier.
// Three-state control: IDLE -> RUN (one partial-product row per clock) -> FIN.
package mult_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // The iteration counter must hold 0..N.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rca_Nbit_co.sv
// Ripple-carry adder with carry-in and carry-out.
// Purely combinational; no handshake.
module rca_Nbit_co #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[W];

endmodule

// File: rtl/mult_seq_mnbit.sv
// Iterative MxN shift-add multiply-accumulate, unsigned or two's-complement per op.
// Latency N+1 edges from start (k+2 with MULT_SEQ_EARLY_TERM_EN, k = MSB index of |b|).
// No backpressure: start is ignored while busy; done is a one-cycle pulse.
module mult_seq_mnbit
    import mult_seq_pkg::*;
#(
    parameter int M     = 4,
    parameter int N     = 4,
    parameter int ACC_W = M + N + 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic             acc_en,
    input  logic             acc_clr,
    input  logic [M-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [M+N-1:0]   product,
    output logic [ACC_W-1:0] acc,
    output logic             acc_ovf
);

    localparam int P  = M + N;
    localparam int CW = cnt_width(N);

    state_t           state;
    logic [P-1:0]     mcand;
    logic [N-1:0]     mplier;
    logic [P-1:0]     partial;
    logic [CW-1:0]    cnt;
    logic             sign_r;
    logic             sm_r;
    logic             ae_r;

    logic [M-1:0]     a_mag;
    logic [N-1:0]     b_mag;
    logic [P-1:0]     addend;
    logic [P-1:0]     add_sum;
    logic             add_co;
    logic             unused_add_co;
    logic [P-1:0]     prod_nx;
    logic [ACC_W-1:0] ext_p;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   acc_wide;
    logic             new_ovf;
    logic             run_last;

    // The sum never carries out: |a|*|b| always fits in M+N bits.
    assign unused_add_co = add_co;

    rca_Nbit_co #(.W(P)) u_add (
        .a  (partial),
        .b  (addend),
        .ci (1'b0),
        .s  (add_sum),
        .co (add_co)
    );

    always_comb begin
        a_mag    = (signed_mode && a[M-1]) ? (~a + 1'b1) : a;
        b_mag    = (signed_mode && b[N-1]) ? (~b + 1'b1) : b;
        addend   = mplier[0] ? mcand : '0;
        prod_nx  = sign_r ? (~partial + 1'b1) : partial;
        ext_p    = sm_r ? ACC_W'($signed(prod_nx)) : ACC_W'(prod_nx);
        // A clear coinciding with FIN makes this add start from zero.
        acc_base = (ae_r && !acc_clr) ? acc : '0;
        acc_wide = {1'b0, acc_base} + {1'b0, ext_p};
        if (sm_r)
            new_ovf = (acc_base[ACC_W-1] == ext_p[ACC_W-1]) &&
                      (acc_wide[ACC_W-1] != acc_base[ACC_W-1]);
        else
            new_ovf = acc_wide[ACC_W];
`ifdef MULT_SEQ_EARLY_TERM_EN
        run_last = (mplier[N-1:1] == '0) || (cnt == CW'(N - 1));
`else
        run_last = (cnt == CW'(N - 1));
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            partial <= '0;
            cnt     <= '0;
            sign_r  <= 1'b0;
            sm_r    <= 1'b0;
            ae_r    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else begin
            done <= 1'b0;
            if (acc_clr) begin
                acc     <= '0;
                acc_ovf <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        sm_r    <= signed_mode;
                        ae_r    <= acc_en;
                        sign_r  <= signed_mode & (a[M-1] ^ b[N-1]);
                        mcand   <= {{N{1'b0}}, a_mag};
                        mplier  <= b_mag;
                        partial <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    partial <= add_sum;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    cnt     <= cnt + 1'b1;
                    if (run_last)
                        state <= FIN;
                end
                FIN: begin
                    product <= prod_nx;
                    acc     <= acc_wide[ACC_W-1:0];
                    acc_ovf <= (acc_ovf & ~acc_clr) | new_ovf;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_mnbit.sv
// Self-checking bench for mult_seq_mnbit (M=N=4, ACC_W=12) against an arithmetic reference model.
module tb_mult_seq_mnbit;

    localparam int M     = 4;
    localparam int N     = 4;
    localparam int ACC_W = 12;
`ifdef MULT_SEQ_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             signed_mode = 1'b0;
    logic             acc_en = 1'b0;
    logic             acc_clr = 1'b0;
    logic [M-1:0]     a = '0;
    logic [N-1:0]     b = '0;
    logic             busy;
    logic             done;
    logic [M+N-1:0]   product;
    logic [ACC_W-1:0] acc;
    logic             acc_ovf;

    int total = 0;
    int bad   = 0;
    int m_acc = 0;
    bit m_ovf = 1'b0;

    mult_seq_mnbit #(.M(M), .N(N), .ACC_W(ACC_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .acc_en      (acc_en),
        .acc_clr     (acc_clr),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .product     (product),
        .acc         (acc),
        .acc_ovf     (acc_ovf)
    );

    always #5 clk = ~clk;

    function automatic int sval(input logic [3:0] v, input logic sm);
        return (sm && v[3]) ? int'(v) - 16 : int'(v);
    endfunction

    function automatic int exp_lat(input logic [3:0] vb, input logic sm);
        int mag;
        int k;
        mag = sval(vb, sm);
        if (mag < 0) mag = -mag;
        k = -1;
        for (int i = 0; i < 4; i++)
            if (((mag >> i) & 1) == 1) k = i;
        if (!EARLY) return N + 1;
        return (k < 0) ? 2 : k + 2;
    endfunction

    // Reference: exact integer product, accumulator as an integer wrapped to ACC_W bits.
    task automatic model_op(input logic [3:0] ia, input logic [3:0] ib, input logic sm,
                            input logic ae, input int clr_at, output int xprod);
        int p, base, sum, xl;
        xl = exp_lat(ib, sm);
        p = sval(ia, sm) * sval(ib, sm);
        xprod = p & 255;
        if (clr_at > 0 && clr_at < xl) begin
            m_acc = 0;
            m_ovf = 1'b0;
        end
        if (clr_at == xl) m_ovf = 1'b0;
        base = 0;
        if (ae && clr_at != xl)
            base = sm ? ((m_acc >= 2048) ? m_acc - 4096 : m_acc) : m_acc;
        sum = base + p;
        if (sm ? (sum < -2048 || sum > 2047) : (sum > 4095)) m_ovf = 1'b1;
        m_acc = sum & 4095;
    endtask

    task automatic run_op(input logic [3:0] ia, input logic [3:0] ib, input logic sm,
                          input logic ae, input int clr_at, output int lat, output int xprod);
        @(negedge clk);
        a = ia; b = ib; signed_mode = sm; acc_en = ae; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 4'($urandom); b = 4'($urandom);
        signed_mode = 1'($urandom); acc_en = 1'($urandom);
        lat = -1;
        for (int e = 1; e <= 20; e++) begin
            acc_clr = (e == clr_at);
            @(posedge clk); #1;
            acc_clr = 1'b0;
            if (done === 1'b1) begin
                lat = e;
                break;
            end
        end
        model_op(ia, ib, sm, ae, clr_at, xprod);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (product !== '0)   begin bad++; $display("FAIL reset_product got=%h want=00", product); end
        total++; if (acc !== '0)       begin bad++; $display("FAIL reset_acc got=%h want=000", acc); end
        total++; if (acc_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", acc_ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = 0;
        m_ovf = 1'b0;
    endtask

    task automatic test_unsigned;
        int lat, xp;
        run_op(4'd13, 4'd11, 1'b0, 1'b0, 0, lat, xp);
        total++; if (lat != exp_lat(4'd11, 1'b0)) begin bad++; $display("FAIL uns_latency got=%0d want=%0d", lat, exp_lat(4'd11, 1'b0)); end
        total++; if (product !== 8'h8F) begin bad++; $display("FAIL uns_product got=%h want=8f", product); end
        total++; if (acc !== 12'h08F)   begin bad++; $display("FAIL uns_acc got=%h want=08f", acc); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL uns_busy got=%b want=0", busy); end
    endtask

    task automatic test_signed;
        int lat, xp;
        run_op(4'h8, 4'h8, 1'b1, 1'b0, 0, lat, xp);
        total++; if (product !== 8'(xp)) begin bad++; $display("FAIL sgn_m8m8 got=%h want=%h", product, 8'(xp)); end
        run_op(4'hD, 4'h5, 1'b1, 1'b0, 0, lat, xp);
        total++; if (product !== 8'hF1)  begin bad++; $display("FAIL sgn_m3x5 got=%h want=f1", product); end
        total++; if (acc !== 12'hFF1)    begin bad++; $display("FAIL sgn_m3x5_acc got=%h want=ff1", acc); end
        total++; if (lat != exp_lat(4'h5, 1'b1)) begin bad++; $display("FAIL sgn_latency got=%0d want=%0d", lat, exp_lat(4'h5, 1'b1)); end
    endtask

    task automatic test_accumulate;
        int lat, xp;
        run_op(4'd7, 4'd7, 1'b1, 1'b0, 0, lat, xp);
        for (int i = 0; i < 2; i++) begin
            run_op(4'd7, 4'd7, 1'b1, 1'b1, 0, lat, xp);
            total++; if (acc !== 12'(m_acc)) begin bad++; $display("FAIL accum_step%0d got=%0d want=%0d", i, acc, m_acc); end
        end
        total++; if (acc !== 12'd147) begin bad++; $display("FAIL accum_147 got=%0d want=147", acc); end
        run_op(4'h8, 4'd7, 1'b1, 1'b1, 0, lat, xp);
        total++; if (acc !== 12'd91)  begin bad++; $display("FAIL accum_91 got=%0d want=91", acc); end
        total++; if (acc_ovf !== 1'b0) begin bad++; $display("FAIL accum_ovf got=%b want=0", acc_ovf); end
    endtask

    task automatic test_overflow;
        int lat, xp;
        @(negedge clk); acc_clr = 1'b1;
        @(posedge clk); #1; acc_clr = 1'b0;
        m_acc = 0; m_ovf = 1'b0;
        total++; if (acc !== '0 || acc_ovf !== 1'b0) begin bad++; $display("FAIL ovf_preclear acc=%h ovf=%b want 000/0", acc, acc_ovf); end
        for (int i = 1; i <= 19; i++) begin
            run_op(4'd15, 4'd15, 1'b0, 1'b1, 0, lat, xp);
            total++; if (acc_ovf !== m_ovf) begin bad++; $display("FAIL ovf_op%0d got=%b want=%b", i, acc_ovf, m_ovf); end
        end
        total++; if (acc !== 12'd179)  begin bad++; $display("FAIL ovf_acc got=%0d want=179", acc); end
        total++; if (acc_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", acc_ovf); end
    endtask

    task automatic test_clr_fin;
        int lat, xp;
        // clear landing on the FIN edge: prior acc and sticky flag discarded
        run_op(4'd2, 4'd3, 1'b0, 1'b1, exp_lat(4'd3, 1'b0), lat, xp);
        total++; if (acc !== 12'd6)    begin bad++; $display("FAIL clrfin_acc got=%0d want=6", acc); end
        total++; if (acc_ovf !== 1'b0) begin bad++; $display("FAIL clrfin_ovf got=%b want=0", acc_ovf); end
        run_op(4'd9, 4'd11, 1'b0, 1'b1, 2, lat, xp);
        total++; if (acc !== 12'(m_acc)) begin bad++; $display("FAIL clrrun_acc got=%0d want=%0d", acc, m_acc); end
        @(negedge clk); acc_clr = 1'b1;
        @(posedge clk); #1; acc_clr = 1'b0;
        m_acc = 0; m_ovf = 1'b0;
        total++; if (acc !== '0 || acc_ovf !== 1'b0) begin bad++; $display("FAIL clridle acc=%h ovf=%b want 000/0", acc, acc_ovf); end
    endtask

    task automatic test_back_to_back;
        int xp, xl, t1, t2;
        xl = exp_lat(4'd9, 1'b0);
        @(negedge clk);
        a = 4'd6; b = 4'd9; signed_mode = 1'b0; acc_en = 1'b0; start = 1'b1;
        t1 = -1; t2 = -1;
        @(posedge clk); #1;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                if (t1 < 0) t1 = e;
                else begin
                    t2 = e;
                    start = 1'b0;
                    break;
                end
            end
        end
        model_op(4'd6, 4'd9, 1'b0, 1'b0, 0, xp);
        model_op(4'd6, 4'd9, 1'b0, 1'b0, 0, xp);
        total++; if (t1 != xl)     begin bad++; $display("FAIL b2b_first got=%0d want=%0d", t1, xl); end
        total++; if (t2 - t1 != xl + 1) begin bad++; $display("FAIL b2b_gap got=%0d want=%0d", t2 - t1, xl + 1); end
        total++; if (product !== 8'(xp)) begin bad++; $display("FAIL b2b_product got=%h want=%h", product, 8'(xp)); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_no_third got=%b want=0", busy); end
    endtask

    task automatic test_start_ignored;
        int xp, lat;
        @(negedge clk);
        a = 4'd13; b = 4'd11; signed_mode = 1'b0; acc_en = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int e = 1; e <= 20; e++) begin
            start = (e == 2);
            a = 4'd2; b = 4'd2;
            @(posedge clk); #1;
            start = 1'b0;
            if (e == 1) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL ign_busy got=%b want=1", busy); end
            end
            if (done === 1'b1) begin lat = e; break; end
        end
        model_op(4'd13, 4'd11, 1'b0, 1'b0, 0, xp);
        total++; if (lat != exp_lat(4'd11, 1'b0)) begin bad++; $display("FAIL ign_latency got=%0d want=%0d", lat, exp_lat(4'd11, 1'b0)); end
        total++; if (product !== 8'(xp)) begin bad++; $display("FAIL ign_product got=%h want=%h", product, 8'(xp)); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL ign_done_pulse got=%b want=0", done); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_restart got=%b want=0", busy); end
    endtask

    task automatic test_reset_abort;
        int lat, xp;
        int seen;
        run_op(4'd5, 4'd5, 1'b0, 1'b0, 0, lat, xp);
        total++; if (acc !== 12'(m_acc)) begin bad++; $display("FAIL abort_pre got=%0d want=%0d", acc, m_acc); end
        @(negedge clk);
        a = 4'd13; b = 4'd11; signed_mode = 1'b0; acc_en = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_acc = 0; m_ovf = 1'b0;
        total++; if ({busy, done, acc_ovf} !== 3'b000) begin bad++; $display("FAIL abort_ctrl got=%b want=000", {busy, done, acc_ovf}); end
        total++; if (product !== '0 || acc !== '0) begin bad++; $display("FAIL abort_data prod=%h acc=%h want 0", product, acc); end
        seen = 0;
        for (int e = 0; e < N + 4; e++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", seen); end
    endtask

    task automatic test_early_term;
        int lat, xp;
        run_op(4'd5, 4'd0, 1'b0, 1'b0, 0, lat, xp);
        total++; if (lat != exp_lat(4'd0, 1'b0)) begin bad++; $display("FAIL et_b0_latency got=%0d want=%0d", lat, exp_lat(4'd0, 1'b0)); end
        total++; if (product !== 8'(xp)) begin bad++; $display("FAIL et_b0_product got=%h want=%h", product, 8'(xp)); end
        run_op(4'd9, 4'd3, 1'b0, 1'b0, 0, lat, xp);
        total++; if (lat != exp_lat(4'd3, 1'b0)) begin bad++; $display("FAIL et_b3_latency got=%0d want=%0d", lat, exp_lat(4'd3, 1'b0)); end
        total++; if (product !== 8'd27) begin bad++; $display("FAIL et_b3_product got=%0d want=27", product); end
    endtask

    task automatic test_random;
        int lat, xp;
        logic [3:0] ra, rb;
        logic rs, re;
        for (int i = 0; i < 40; i++) begin
            ra = 4'($urandom); rb = 4'($urandom);
            rs = 1'($urandom); re = 1'($urandom);
            run_op(ra, rb, rs, re, 0, lat, xp);
            total++;
            if (lat != exp_lat(rb, rs) || product !== 8'(xp) || acc !== 12'(m_acc) || acc_ovf !== m_ovf || busy !== 1'b0) begin
                bad++;
                $display("FAIL rand%0d a=%h b=%h s=%b e=%b lat=%0d/%0d prod=%h/%h acc=%h/%h ovf=%b/%b",
                         i, ra, rb, rs, re, lat, exp_lat(rb, rs), product, 8'(xp), acc, 12'(m_acc), acc_ovf, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_accumulate;
        test_overflow;
        test_clr_fin;
        test_back_to_back;
        test_start_ignored;
        test_reset_abort;
        test_early_term;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
